inst_prefetch_queue: RTL

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

---
 rtl/inst_prefetch_queue.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: a small circular buffer of {word address, data}
// filled ahead of the CPU PC from instruction memory, flushed on a PC redirect.
module inst_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        CK_REF,
    input  logic        RST_N,
    input  logic        HALT,
    input  logic [31:0] FETCH_ADDR,
    output logic [31:0] INST_OUT,
    output logic        INST_VALID,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DISCARD = 2'b10
    } state_e;

    logic [29:0]   addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [29:0]   pf_addr_q, pf_addr_d;
    logic [29:0]   req_addr_q, req_addr_d;
    state_e        state_q, state_d;
    logic          imem_req_q, imem_req_d;
    logic [31:0]   inst_out_q, inst_out_d;

    logic [29:0]   fetch_word_s;
    logic [1:0]    fetch_lsb_unused_s;
    logic          hit_s;
    logic          inflight_s;
    logic          redirect_s;
    logic          push_s;
    logic          pop_s;

    assign fetch_word_s       = FETCH_ADDR[31:2];
    assign fetch_lsb_unused_s = FETCH_ADDR[1:0];

    // Hit / redirect classification of the current fetch address
    always_comb begin
        hit_s      = (count_q != {CW{1'b0}}) && (addr_mem_q[head_q] == fetch_word_s);
        // The outstanding request covers the fetch address, so it is not a redirect yet
        inflight_s = (state_q != ST_IDLE) && (req_addr_q == fetch_word_s);
        redirect_s = !hit_s && ((count_q != {CW{1'b0}}) ||
                                ((fetch_word_s != pf_addr_q) && !inflight_s));
        push_s     = (state_q == ST_REQ) && IMEM_ACK && !redirect_s;
        pop_s      = hit_s && !HALT;
    end

    assign INST_VALID = hit_s;
    assign INST_OUT   = hit_s ? data_mem_q[head_q] : inst_out_q;
    assign IMEM_REQ   = imem_req_q;
    assign IMEM_ADDR  = {req_addr_q, 2'b00};

    // Next-state for queue pointers, prefetch pointer and request FSM
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pf_addr_d  = pf_addr_q;
        state_d    = state_q;
        req_addr_d = req_addr_q;

        if (redirect_s) begin
            head_d    = {PW{1'b0}};
            tail_d    = {PW{1'b0}};
            count_d   = {CW{1'b0}};
            pf_addr_d = fetch_word_s;
        end else begin
            if (push_s) begin
                tail_d    = tail_q + PW'(1);
                pf_addr_d = pf_addr_q + 30'd1;
            end else begin
                tail_d    = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end

        // Every entry into REQ requests the (possibly redirected) prefetch pointer
        case (state_q)
            ST_IDLE: begin
                if (redirect_s || (count_q < DEPTH_C)) begin
                    state_d    = ST_REQ;
                    req_addr_d = pf_addr_d;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (IMEM_ACK) begin
                    if (redirect_s || (count_d < DEPTH_C)) begin
                        state_d    = ST_REQ;
                        req_addr_d = pf_addr_d;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end else if (redirect_s) begin
                    state_d = ST_DISCARD;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (IMEM_ACK) begin
                    state_d    = ST_REQ;
                    req_addr_d = pf_addr_d;
                end else begin
                    state_d    = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        imem_req_d = (state_d != ST_IDLE);
        inst_out_d = hit_s ? data_mem_q[head_q] : inst_out_q;
    end

    // Control and output registers
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            pf_addr_q  <= 30'd0;
            req_addr_q <= 30'd0;
            state_q    <= ST_IDLE;
            imem_req_q <= 1'b0;
            inst_out_q <= 32'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pf_addr_q  <= pf_addr_d;
            req_addr_q <= req_addr_d;
            state_q    <= state_d;
            imem_req_q <= imem_req_d;
            inst_out_q <= inst_out_d;
        end
    end

    // Queue storage written at the tail on an accepted fetch
    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= 30'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else if (push_s) begin
            addr_mem_q[tail_q] <= pf_addr_q;
            data_mem_q[tail_q] <= IMEM_RDATA;
        end
    end

endmodule
